// File: rtl/bt_frame_pkg.sv
// rtl/bt_frame_pkg.sv - shared constants, state type and byte helper for the frame parser
package bt_frame_pkg;

  localparam int FRAME_BYTES   = 11;
  localparam int PAYLOAD_BYTES = 8;
  localparam int FRAME_W       = 8 * FRAME_BYTES;
  localparam int ENTRY_W       = 8 + 8 * PAYLOAD_BYTES;

  localparam logic [7:0] DEF_HDR_BYTE = 8'h55;
  localparam logic [7:0] DEF_TYPE_MIN = 8'h50;
  localparam logic [7:0] DEF_TYPE_MAX = 8'h5F;

  typedef enum logic [1:0] {IDLE, SUM, CHECK} state_t;

  // Byte k of a raw frame sits at bits [8k+7:8k]; out-of-range indices read as zero.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input logic [3:0] idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (idx == 4'(k)) b = f[8*k +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/bt_frame_fifo.sv
// rtl/bt_frame_fifo.sv - first-word fall-through FIFO holding validated frames
module bt_frame_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/bt_frame_parser.sv
// rtl/bt_frame_parser.sv - takes raw frames from the uart controller, checks them, queues the good ones
module bt_frame_parser
  import bt_frame_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE   = DEF_HDR_BYTE,
  parameter logic [7:0] TYPE_MIN   = DEF_TYPE_MIN,
  parameter logic [7:0] TYPE_MAX   = DEF_TYPE_MAX,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [87:0]          rx_data,
  input  logic                 rx_rdy,
  output logic                 rx_ack,
  output logic [7:0]           out_type,
  output logic [63:0]          out_payload,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [CNT_WIDTH-1:0] err_hdr_cnt,
  output logic [CNT_WIDTH-1:0] err_sum_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  logic [FRAME_W-1:0]   r_frame;
  logic [7:0]           r_acc;
  logic [3:0]           r_idx;
  logic                 r_ack;
  logic [CNT_WIDTH-1:0] r_err_hdr;
  logic [CNT_WIDTH-1:0] r_err_sum;
  logic [CNT_WIDTH-1:0] r_drop;

  logic [7:0]         w_byte;
  logic [7:0]         w_b0;
  logic [7:0]         w_b1;
  logic [7:0]         w_b10;
  logic               w_hdr_ok;
  logic               w_sum_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_ONE;
  endfunction

  assign w_byte   = frame_byte(r_frame, r_idx);
  assign w_b0     = r_frame[7:0];
  assign w_b1     = r_frame[15:8];
  assign w_b10    = r_frame[87:80];
  assign w_hdr_ok = (w_b0 == HDR_BYTE) && (w_b1 >= TYPE_MIN) && (w_b1 <= TYPE_MAX);
  assign w_sum_ok = (r_acc == w_b10);
  assign w_push   = (r_state == CHECK) && w_hdr_ok && w_sum_ok;
  assign w_pop    = out_vld && out_rdy;
  assign w_entry  = {w_b1, r_frame[79:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_frame   <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_ack     <= 1'b0;
      r_err_hdr <= '0;
      r_err_sum <= '0;
      r_drop    <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_rdy) begin
            r_frame <= rx_data;
            r_acc   <= '0;
            r_idx   <= '0;
            r_ack   <= 1'b1;
            r_state <= SUM;
          end
        end
        SUM: begin
          // Bytes 0..9 are summed; byte 10 is the expected checksum.
          r_acc <= r_acc + w_byte;
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd9) r_state <= CHECK;
        end
        CHECK: begin
          if (!w_hdr_ok)              r_err_hdr <= sat_inc(r_err_hdr);
          else if (!w_sum_ok)         r_err_sum <= sat_inc(r_err_sum);
          else if (w_full && !w_pop)  r_drop    <= sat_inc(r_drop);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bt_frame_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_entry),
    .o_full      (w_full),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_empty     (w_empty)
  );

  assign rx_ack      = r_ack;
  assign out_vld     = !w_empty;
  assign out_type    = w_head[71:64];
  assign out_payload = w_head[63:0];
  assign err_hdr_cnt = r_err_hdr;
  assign err_sum_cnt = r_err_sum;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_bt_frame_parser.sv
// tb/tb_bt_frame_parser.sv - directed vector bench for the frame parser
module tb_bt_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [87:0] rx_data = '0;
  logic        rx_rdy = 1'b0;
  logic        out_rdy = 1'b0;

  logic        rx_ack, out_vld;
  logic [7:0]  out_type;
  logic [63:0] out_payload;
  logic [15:0] err_hdr_cnt, err_sum_cnt, drop_cnt;

  logic        s_rx_ack, s_out_vld;
  logic [7:0]  s_out_type;
  logic [63:0] s_out_payload;
  logic [1:0]  s_err_hdr_cnt, s_err_sum_cnt, s_drop_cnt;

  always #5 clk = ~clk;

  bt_frame_parser u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
    .out_type(out_type), .out_payload(out_payload), .out_vld(out_vld), .out_rdy(out_rdy),
    .err_hdr_cnt(err_hdr_cnt), .err_sum_cnt(err_sum_cnt), .drop_cnt(drop_cnt)
  );

  bt_frame_parser #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(s_rx_ack),
    .out_type(s_out_type), .out_payload(s_out_payload), .out_vld(s_out_vld), .out_rdy(out_rdy),
    .err_hdr_cnt(s_err_hdr_cnt), .err_sum_cnt(s_err_sum_cnt), .drop_cnt(s_drop_cnt)
  );

  typedef struct {
    logic [87:0] frame;
    logic [1:0]  kind;   // 0 good, 1 header/type error, 2 checksum error
    logic [7:0]  typ;
    logic [63:0] pay;
  } vec_t;

  vec_t tbl [9];
  int   n_vec = 0;
  int   n_bad = 0;
  int   e_hdr = 0, e_sum = 0, e_drop = 0;
  logic ack_c1, ack_extra, vld_c11, vld_c12;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle 0 = rx_rdy sampled; returns at the negedge of cycle 12.
  task automatic send(input logic [87:0] f, input bit pop_in_check);
    @(negedge clk);
    rx_data = f;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy    = 1'b0;
    ack_c1    = rx_ack;
    ack_extra = 1'b0;
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      if (rx_ack) ack_extra = 1'b1;
      if (c == 11) begin
        vld_c11 = out_vld;
        if (pop_in_check) out_rdy = 1'b1;
      end
    end
    @(negedge clk);
    if (pop_in_check) out_rdy = 1'b0;
    vld_c12 = out_vld;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, " err_hdr"}, 64'(err_hdr_cnt), 64'(e_hdr));
    chk({tag, " err_sum"}, 64'(err_sum_cnt), 64'(e_sum));
    chk({tag, " drop"},    64'(drop_cnt),    64'(e_drop));
  endtask

  task automatic pop_one(input logic [7:0] typ, input logic [63:0] pay);
    @(negedge clk);
    chk("drain vld", 64'(out_vld), 64'd1);
    chk("drain type", 64'(out_type), 64'(typ));
    chk("drain payload", out_payload, pay);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  initial begin
    tbl[0] = '{88'hC2_07_06_05_04_03_02_01_00_51_55, 2'd0, 8'h51, 64'h0706050403020100};
    tbl[1] = '{88'hC3_07_06_05_04_03_02_01_00_51_55, 2'd2, 8'h00, 64'h0};
    tbl[2] = '{88'hC2_07_06_05_04_03_02_01_00_51_AA, 2'd1, 8'h00, 64'h0};
    tbl[3] = '{88'hC2_07_06_05_04_03_02_01_00_60_55, 2'd1, 8'h00, 64'h0};
    tbl[4] = '{88'hA5_00_00_00_00_00_00_00_00_50_55, 2'd0, 8'h50, 64'h0};
    tbl[5] = '{88'hAC_FF_FF_FF_FF_FF_FF_FF_FF_5F_55, 2'd0, 8'h5F, 64'hFFFFFFFFFFFFFFFF};
    tbl[6] = '{88'hA4_00_00_00_00_00_00_00_00_4F_55, 2'd1, 8'h00, 64'h0};
    tbl[7] = '{88'h13_88_77_66_55_44_33_22_11_5A_55, 2'd0, 8'h5A, 64'h8877665544332211};
    tbl[8] = '{88'h14_88_77_66_55_44_33_22_11_5A_55, 2'd2, 8'h00, 64'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ack", 64'(rx_ack), 64'd0);
    chk("reset vld", 64'(out_vld), 64'd0);
    chk("reset type", 64'(out_type), 64'd0);
    chk("reset payload", out_payload, 64'd0);
    chk_cnts("reset");

    out_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].frame, 1'b0);
      chk("vec ack c1", 64'(ack_c1), 64'd1);
      chk("vec ack once", 64'(ack_extra), 64'd0);
      chk("vec vld c11", 64'(vld_c11), 64'd0);
      chk("vec vld c12", 64'(vld_c12), 64'(tbl[i].kind == 2'd0));
      if (tbl[i].kind == 2'd0) begin
        chk("vec type", 64'(out_type), 64'(tbl[i].typ));
        chk("vec payload", out_payload, tbl[i].pay);
      end
      if (tbl[i].kind == 2'd1) e_hdr++;
      if (tbl[i].kind == 2'd2) e_sum++;
      chk_cnts("vec");
    end
    @(negedge clk);
    chk("vec drained", 64'(out_vld), 64'd0);

    // Fill the queue with out_rdy low; the fifth good frame is dropped.
    out_rdy = 1'b0;
    send(tbl[0].frame, 1'b0);
    send(tbl[4].frame, 1'b0);
    send(tbl[5].frame, 1'b0);
    send(tbl[7].frame, 1'b0);
    chk_cnts("fill");
    send(tbl[0].frame, 1'b0);
    e_drop = 1;
    chk_cnts("full drop");
    chk("full head type", 64'(out_type), 64'h51);
    // Pop during CHECK of a sixth frame frees a slot for it.
    send(tbl[5].frame, 1'b1);
    chk_cnts("full pop+push");
    pop_one(8'h50, 64'h0);
    pop_one(8'h5F, 64'hFFFFFFFFFFFFFFFF);
    pop_one(8'h5A, 64'h8877665544332211);
    pop_one(8'h5F, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    chk("full drained", 64'(out_vld), 64'd0);

    // Leave one frame queued, then reset in the middle of another.
    send(tbl[7].frame, 1'b0);
    chk("pre-rst vld", 64'(vld_c12), 64'd1);
    @(negedge clk);
    rx_data = tbl[1].frame;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_hdr = 0; e_sum = 0; e_drop = 0;
    chk("midrst ack", 64'(rx_ack), 64'd0);
    chk("midrst vld", 64'(out_vld), 64'd0);
    chk_cnts("midrst");
    repeat (12) @(negedge clk);
    chk_cnts("midrst abandoned");
    chk("midrst no push", 64'(out_vld), 64'd0);

    out_rdy = 1'b1;
    send(tbl[0].frame, 1'b0);
    chk("post-rst ack", 64'(ack_c1), 64'd1);
    chk("post-rst vld c11", 64'(vld_c11), 64'd0);
    chk("post-rst vld c12", 64'(vld_c12), 64'd1);
    chk("post-rst type", 64'(out_type), 64'h51);

    for (int k = 1; k <= 5; k++) begin
      send(tbl[1].frame, 1'b0);
      e_sum++;
      chk_cnts("sat main");
      chk("sat err_sum", 64'(s_err_sum_cnt), 64'((k > 3) ? 3 : k));
      chk("sat err_hdr", 64'(s_err_hdr_cnt), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
